// File: rtl/uart_pkg.sv
// Shared types for the UART transceiver: TX/RX state encodings and a bit-timer width helper.
// No logic of its own; the parity states exist only when UART_PARITY_EN is defined.
// Pure declarations, so no timing or backpressure applies here.
package uart_pkg;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_state_t;
`endif

  // Width of a counter that must hold 0 .. clks-1.
  function automatic int cnt_w(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// Head word is visible combinationally; a push shows up at the head one cycle later.
// Push while full is dropped unless a pop in the same cycle frees the slot; pop while empty is ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty FIFO presents zero so the head output is defined out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both wrap naturally through the extra MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Parametrised UART with TX/RX FIFOs and sticky errors; optional parity via UART_PARITY_EN.
// TX: push into idle FIFO drives the start bit one cycle later. RX: word visible two cycles after the stop sample.
// tx_ready drops when the TX FIFO is full; RX words arriving at a full FIFO are dropped and flagged.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
`ifdef UART_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        UART_RX,
  output logic                        UART_TX,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_read,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  input  logic                        err_clr,
  output logic                        rx_overrun,
  output logic                        frame_err,
  output logic                        parity_err
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_END = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS - 1);

  // ---------------- reset: async assert, sync release ----------------
  logic [1:0] rst_pipe;
  logic       rst;

  // Two-stage release so every flop leaves reset on the same edge.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst = rst_pipe[1];

  // ---------------- TX ----------------
  tx_state_t                  tx_state, tx_next;
  logic [CW-1:0]              tx_cnt;
  logic [BW-1:0]              tx_bit;
  logic [DATA_BITS-1:0]       tx_sh;
  logic [DATA_BITS-1:0]       tx_head;
  logic                       tx_full, tx_empty, tx_pop, tx_tick;
  logic [$clog2(FIFO_DEPTH):0] tx_level;
`ifdef UART_PARITY_EN
  logic                       tx_par;
`endif

  assign tx_ready = !tx_full;
  assign tx_busy  = (tx_level != '0) || (tx_state != TX_IDLE);
  assign tx_tick  = (tx_state != TX_IDLE) && (tx_cnt == BIT_END);

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (sysclk),
    .rst       (rst),
    .push      (tx_valid && !tx_full),
    .push_data (tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_level)
  );

  // TX state register.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  // TX next state: each bit lasts one bit period; STOP chains straight into START when more data waits.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (!tx_empty) tx_next = TX_START;
      TX_START:  if (tx_tick) tx_next = TX_DATA;
`ifdef UART_PARITY_EN
      TX_DATA:   if (tx_tick && tx_bit == DATA_END) tx_next = TX_PARITY;
      TX_PARITY: if (tx_tick) tx_next = TX_STOP;
`else
      TX_DATA:   if (tx_tick && tx_bit == DATA_END) tx_next = TX_STOP;
`endif
      TX_STOP:   if (tx_tick && tx_bit == STOP_END) tx_next = tx_empty ? TX_IDLE : TX_START;
      default:   tx_next = TX_IDLE;
    endcase
  end

  // TX outputs: line level per state, and the FIFO pop that coincides with entering START.
  always_comb begin
    tx_pop  = 1'b0;
    UART_TX = 1'b1;
    case (tx_state)
      TX_IDLE:   tx_pop = !tx_empty;
      TX_START:  UART_TX = 1'b0;
      TX_DATA:   UART_TX = tx_sh[0];
`ifdef UART_PARITY_EN
      TX_PARITY: UART_TX = tx_par;
`endif
      TX_STOP:   tx_pop = tx_tick && (tx_bit == STOP_END) && !tx_empty;
      default:   UART_TX = 1'b1;
    endcase
  end

  // TX bit timer, bit index (data bits, then stop bits) and LSB-first shifter.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      if (tx_state == TX_IDLE || tx_state != tx_next) begin
        tx_cnt <= '0;
        tx_bit <= '0;
      end else if (tx_tick) begin
        tx_cnt <= '0;
        tx_bit <= tx_bit + 1'b1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
      if (tx_pop)                            tx_sh <= tx_head;
      else if (tx_state == TX_DATA && tx_tick) tx_sh <= tx_sh >> 1;
    end
  end

`ifdef UART_PARITY_EN
  // Parity bit is fixed when the word is loaded.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst)         tx_par <= 1'b0;
    else if (tx_pop) tx_par <= (^tx_head) ^ PARITY_ODD;
  end
`endif

  // ---------------- RX ----------------
  rx_state_t            rx_state, rx_next;
  logic                 rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_samp, rx_wr, rx_full, rx_empty;
  logic                 ovr_set, ferr_set;
  logic                 ovr_q, ferr_q;

  assign rx_valid   = !rx_empty;
  assign rx_overrun = ovr_q;
  assign frame_err  = ferr_q;
  assign ovr_set    = rx_wr && rx_full && !rx_read;
  assign ferr_set   = (rx_state == RX_STOP) && rx_samp && !rx_s2;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (sysclk),
    .rst       (rst),
    .push      (rx_wr),
    .push_data (rx_sh),
    .pop       (rx_read),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle line is high.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= UART_RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX state register.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // RX next state: mid-start check rejects glitches; a low stop bit parks in WAIT until the line reads high.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_prev && !rx_s2) rx_next = RX_START;
      RX_START:  if (rx_samp) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
      RX_DATA:   if (rx_samp && rx_bit == DATA_END) rx_next = RX_PARITY;
      RX_PARITY: if (rx_samp) rx_next = RX_STOP;
`else
      RX_DATA:   if (rx_samp && rx_bit == DATA_END) rx_next = RX_STOP;
`endif
      RX_STOP:   if (rx_samp) rx_next = rx_s2 ? RX_IDLE : RX_WAIT;
      RX_WAIT:   if (rx_samp && rx_s2) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  // RX sample strobe: half a bit into START, then one full bit period after each previous sample.
  always_comb begin
    rx_samp = 1'b0;
    case (rx_state)
      RX_START: rx_samp = (rx_cnt == HALF_END);
      RX_IDLE:  rx_samp = 1'b0;
      default:  rx_samp = (rx_cnt == BIT_END);
    endcase
  end

  // RX bit timer, data shifter and the one-cycle-delayed FIFO write of an accepted word.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
      rx_wr  <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || rx_state != rx_next || rx_samp) rx_cnt <= '0;
      else                                                     rx_cnt <= rx_cnt + 1'b1;
      if (rx_state != rx_next)                  rx_bit <= '0;
      else if (rx_state == RX_DATA && rx_samp)  rx_bit <= rx_bit + 1'b1;
      if (rx_state == RX_DATA && rx_samp) rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
      rx_wr <= (rx_state == RX_STOP) && rx_samp && rx_s2;
    end
  end

  // Sticky overrun and framing flags; a new event wins over a clear in the same cycle.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & ~err_clr);
      ferr_q <= ferr_set | (ferr_q & ~err_clr);
    end
  end

`ifdef UART_PARITY_EN
  logic par_bad;
  logic perr_q;
  assign parity_err = perr_q;

  // Parity verdict is held from its sample until the word is written; the flag follows the write.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      par_bad <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (rx_state == RX_PARITY && rx_samp) par_bad <= rx_s2 ^ (^rx_sh) ^ PARITY_ODD;
      perr_q <= (rx_wr && par_bad) | (perr_q & ~err_clr);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: serial frames decoded/generated from the line format, queue-based FIFO model.
// Randomised data words; expected values come from the frame rules and a model queue of stored words.
// Summary line reports compared / mismatched counts.
module tb_uart_fifo_ctrl;

  localparam int C     = 16;
  localparam int DB    = 8;
  localparam int SB    = 1;
  localparam int DEPTH = 16;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam bit PODD      = 1'b0;
  localparam int FL        = 1 + DB + PB + SB;
  localparam int FRAME_CYC = FL * C;

  logic sysclk = 1'b0, reset = 1'b0, UART_RX = 1'b1;
  logic tx_valid = 1'b0, rx_read = 1'b0, err_clr = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic UART_TX, tx_ready, rx_valid, tx_busy, rx_overrun, frame_err, parity_err;
  logic [DB-1:0] rx_data;
  logic [$clog2(DEPTH):0] rx_count;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int mon_word[$];
  int mon_start[$];
  bit mon_ok[$];
  bit mon_par[$];
  logic [DB-1:0] txq[$];
  logic [DB-1:0] rxq[$];
  bit m_ovr = 0, m_ferr = 0, m_perr = 0;
  bit mon_prev = 1'b1;

  uart_fifo_ctrl #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB),
    .FIFO_DEPTH   (DEPTH)
`ifdef UART_PARITY_EN
    ,
    .PARITY_ODD   (PODD)
`endif
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .UART_RX    (UART_RX),
    .UART_TX    (UART_TX),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_read    (rx_read),
    .tx_busy    (tx_busy),
    .rx_count   (rx_count),
    .err_clr    (err_clr),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge sysclk); #1; end
  endtask

  task automatic mwait(input int n);
    repeat (n) begin @(posedge sysclk); #2; end
  endtask

  // Expected line level of bit slot j of a frame carrying d.
  function automatic bit exp_bit(input logic [DB-1:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= DB) return d[j-1];
    if (PB == 1 && j == DB + 1) return (^d) ^ PODD;
    return 1'b1;
  endfunction

  // Line monitor: decodes every TX frame from the pin, sampling at bit centres.
  initial begin
    logic [DB-1:0] w;
    bit ok, p;
    int st;
    forever begin
      @(posedge sysclk); #2;
      if (mon_prev && !UART_TX) begin
        st = cyc; ok = 1'b1; w = '0; p = 1'b0;
        mwait(C / 2);
        if (UART_TX) ok = 1'b0;
        for (int i = 0; i < DB; i++) begin mwait(C); w[i] = UART_TX; end
`ifdef UART_PARITY_EN
        mwait(C); p = UART_TX;
`endif
        for (int s = 0; s < SB; s++) begin mwait(C); if (!UART_TX) ok = 1'b0; end
        mon_word.push_back(int'(w));
        mon_start.push_back(st);
        mon_ok.push_back(ok);
        mon_par.push_back(p);
      end
      mon_prev = UART_TX;
    end
  end

  task automatic mon_clear();
    mon_word.delete(); mon_start.delete(); mon_ok.delete(); mon_par.delete(); txq.delete();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (mon_word.size() < n && t < budget) begin tick(1); t++; end
    chk("tx_frame_count", mon_word.size(), n);
  endtask

  // Back-to-back pushes; the first n_acc are expected to be accepted.
  task automatic push_burst(input int n, input int n_acc);
    for (int k = 0; k < n; k++) begin
      tx_data  = DB'($urandom);
      tx_valid = 1'b1;
      chk("tx_ready", tx_ready, (k < n_acc) ? 1 : 0);
      if (k < n_acc) txq.push_back(tx_data);
      tick(1);
    end
    tx_valid = 1'b0;
  endtask

  task automatic check_frames(input int n);
    wait_frames(n, (n + 2) * FRAME_CYC);
    for (int i = 0; i < n && i < mon_word.size(); i++) begin
      chk("tx_word", mon_word[i], txq[i]);
      chk("tx_frame_ok", mon_ok[i], 1);
      if (i > 0) chk("tx_gap", mon_start[i] - mon_start[i-1], FRAME_CYC);
    end
  endtask

  task automatic send_rx(input logic [DB-1:0] d, input bit stop_ok, input bit par_ok);
    UART_RX = 1'b0; tick(C);
    for (int i = 0; i < DB; i++) begin UART_RX = d[i]; tick(C); end
`ifdef UART_PARITY_EN
    UART_RX = (^d) ^ PODD ^ !par_ok; tick(C);
`endif
    UART_RX = stop_ok; tick(C);
    UART_RX = 1'b1; tick(stop_ok ? C : 2 * C);
    if (stop_ok) begin
      if (rxq.size() < DEPTH) rxq.push_back(d);
      else m_ovr = 1'b1;
      if (!par_ok) m_perr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic rd_check();
    chk("rx_valid", rx_valid, (rxq.size() != 0) ? 1 : 0);
    if (rxq.size() != 0) chk("rx_data", rx_data, rxq[0]);
    rx_read = 1'b1; tick(1); rx_read = 1'b0;
    if (rxq.size() != 0) void'(rxq.pop_front());
    chk("rx_count", rx_count, rxq.size());
  endtask

  task automatic flags_check();
    chk("rx_overrun", rx_overrun, m_ovr);
    chk("frame_err", frame_err, m_ferr);
    chk("parity_err", parity_err, m_perr);
  endtask

  task automatic clr_err();
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    m_ovr = 0; m_ferr = 0; m_perr = 0;
    flags_check();
  endtask

  initial begin
    logic [DB-1:0] d;
    #2 reset = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(4);
    mon_clear();

    // Reset state
    chk("rst_uart_tx", UART_TX, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_rx_data", rx_data, 0);
    flags_check();

    // Single TX word with exact timing
    tx_data = 8'h55; tx_valid = 1'b1; txq.push_back(8'h55);
    tick(1);
    tx_valid = 1'b0;
    chk("tx_still_idle", UART_TX, 1);
    chk("tx_busy_push", tx_busy, 1);
    tick(1);
    chk("tx_start_low", UART_TX, 0);
    for (int k = 1; k <= FRAME_CYC; k++) begin
      tick(1);
      if (k < FRAME_CYC && (k % C) == C / 2) chk("tx_bit", UART_TX, exp_bit(8'h55, k / C));
      if (k == FRAME_CYC - 1) chk("tx_busy_stop", tx_busy, 1);
    end
    chk("tx_busy_done", tx_busy, 0);
    chk("tx_idle_high", UART_TX, 1);
    check_frames(1);

    // Four back-to-back words
    mon_clear();
    push_burst(4, 4);
    check_frames(4);
    tick(FRAME_CYC);
    chk("tx_busy_idle", tx_busy, 0);

    // Fill the TX FIFO: one word in flight plus DEPTH queued
    mon_clear();
    push_burst(DEPTH + 4, DEPTH + 1);
    chk("tx_ready_full", tx_ready, 0);
    check_frames(DEPTH + 1);
    tick(FRAME_CYC);

`ifdef UART_PARITY_EN
    mon_clear();
    tx_data = 8'h07; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    wait_frames(1, 3 * FRAME_CYC);
    if (mon_par.size() > 0) chk("tx_parity_07", mon_par[0], 1);
    tick(FRAME_CYC);
`endif

    // Single RX word
    send_rx(8'hA3, 1'b1, 1'b1);
    chk("rx_count_one", rx_count, 1);
    rd_check();
    chk("rx_valid_after_read", rx_valid, 0);
    rd_check();

    // Overflow the RX FIFO
    for (int i = 0; i < DEPTH + 1; i++) send_rx(DB'($urandom), 1'b1, 1'b1);
    chk("rx_count_full", rx_count, rxq.size());
    flags_check();
    for (int i = 0; i < DEPTH; i++) rd_check();
    clr_err();

    // Bad stop bit, then a short glitch on the idle line
    send_rx(DB'($urandom), 1'b0, 1'b1);
    chk("ferr_no_write", rx_count, rxq.size());
    flags_check();
    clr_err();
    UART_RX = 1'b0; tick(5); UART_RX = 1'b1; tick(3 * C);
    chk("glitch_no_write", rx_count, rxq.size());
    chk("glitch_no_valid", rx_valid, 0);
    flags_check();

`ifdef UART_PARITY_EN
    send_rx(8'h07, 1'b1, 1'b0);
    flags_check();
    rd_check();
    clr_err();
`endif

    // Random mix of good/bad frames and reads
    for (int it = 0; it < 10; it++) begin
      d = DB'($urandom);
      send_rx(d, ($urandom_range(0, 4) != 0), 1'b1);
      chk("mix_count", rx_count, rxq.size());
      flags_check();
      for (int r = $urandom_range(0, 2); r > 0; r--) rd_check();
    end
    while (rxq.size() != 0) rd_check();

    // Reset in the middle of a TX frame
    tx_data = DB'($urandom); tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    tick(3 * C);
    chk("tx_busy_midframe", tx_busy, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_tx_high", UART_TX, 1);
    chk("rst_mid_busy", tx_busy, 0);
    tick(3);
    reset = 1'b0;
    tick(4);
    chk("rst_mid_rx_count", rx_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
